dmem_responder: RTL and testbench

Data-memory responder for the RV32 pipeline. It serves the MEM stage's read and write request interface and returns read data, a ready pulse and a fault flag after a programmable latency. It is a single-ported word array with byte and halfword lanes, load sign/zero extension and alignment checking. It sits between the MEM stage and the data RAM model in the core top level.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 82 ++++++++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 types: load/store width selectors (funct3-style encodings) and the
// data-memory responder FSM states.
package rv32_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_sel_e;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } store_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane steering for dmem_responder: store byte enables and lane
// data, load extension, selector and alignment checks (DMEM_MISALIGN_TRAP_EN).
module dmem_lane_align
  import rv32_pkg::*;
(
  input  logic        i_is_write,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_load_sel,
  input  logic [1:0]  i_store_sel,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_sel_bad,
  output logic        o_misalign
);

  logic       w_half;
  logic       w_word;
  logic [1:0] w_off;
  logic [7:0] w_byte;
  logic [15:0] w_hw;

  always_comb begin
    w_half = i_is_write ? (i_store_sel == SH) : ((i_load_sel == LH) || (i_load_sel == LHU));
    w_word = i_is_write ? (i_store_sel == SW) : (i_load_sel == LW);
    w_off  = i_addr_lo;
`ifdef DMEM_MISALIGN_TRAP_EN
    o_misalign = (w_half && i_addr_lo[0]) || (w_word && (i_addr_lo != 2'b00));
`else
    // Without trapping, the offending low bits are dropped (access aligned down).
    if (w_half) w_off[0] = 1'b0;
    if (w_word) w_off    = 2'b00;
    o_misalign = 1'b0;
`endif
  end

  always_comb begin
    case (w_off)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_hw = w_off[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_be      = '0;
    o_wdata   = '0;
    o_rdata   = '0;
    o_sel_bad = 1'b0;
    if (i_is_write) begin
      case (i_store_sel)
        SB: begin
          o_be    = 4'b0001 << w_off;
          o_wdata = {4{i_wdata[7:0]}};
        end
        SH: begin
          o_be    = w_off[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        SW: begin
          o_be    = '1;
          o_wdata = i_wdata;
        end
        default: o_sel_bad = 1'b1;
      endcase
    end else begin
      case (i_load_sel)
        LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
        LH:      o_rdata = {{16{w_hw[15]}}, w_hw};
        LW:      o_rdata = i_rword;
        LBU:     o_rdata = {24'd0, w_byte};
        LHU:     o_rdata = {16'd0, w_hw};
        default: o_sel_bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-ported word array answering MEM-stage requests
// after LATENCY cycles. Optional alignment trap via DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  store_sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_e r_state;
  dmem_state_e w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_load_sel;
  logic [1:0]  r_store_sel;
  logic        r_is_write;
  logic        r_invalid;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle;
  logic        w_accept;
  logic [31:0] w_src_addr;
  logic [31:0] w_src_wdata;
  logic [2:0]  w_src_load_sel;
  logic [1:0]  w_src_store_sel;
  logic        w_src_write;
  logic        w_src_invalid;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_sel_bad;
  logic        w_misalign;
  logic        w_fault;
  logic        w_ready_nxt;
  logic        w_fault_nxt;
  logic [31:0] w_rdata_nxt;

  // In IDLE the live request feeds the checks so LATENCY=1 can respond on the
  // very next cycle; otherwise the captured request is used.
  always_comb begin
    w_idle          = (r_state == IDLE);
    w_accept        = w_idle && (mem_read_enable || mem_write_enable);
    w_src_addr      = w_idle ? mem_addr  : r_addr;
    w_src_wdata     = w_idle ? mem_wdata : r_wdata;
    w_src_load_sel  = w_idle ? load_sel  : r_load_sel;
    w_src_store_sel = w_idle ? store_sel : r_store_sel;
    w_src_write     = w_idle ? (mem_write_enable && !mem_read_enable) : r_is_write;
    w_src_invalid   = w_idle ? (mem_write_enable && mem_read_enable)  : r_invalid;
    w_idx           = w_src_addr[AW+1:2];
    w_rword         = r_mem[w_idx];
    w_fault         = w_src_invalid || w_sel_bad || w_misalign ||
                      (w_src_addr[31:2] >= 30'(DEPTH_WORDS));
  end

  dmem_lane_align u_lane (
    .i_is_write  (w_src_write),
    .i_addr_lo   (w_src_addr[1:0]),
    .i_load_sel  (w_src_load_sel),
    .i_store_sel (w_src_store_sel),
    .i_wdata     (w_src_wdata),
    .i_rword     (w_rword),
    .o_be        (w_be),
    .o_wdata     (w_lane_wdata),
    .o_rdata     (w_lane_rdata),
    .o_sel_bad   (w_sel_bad),
    .o_misalign  (w_misalign)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt <= 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_next == RESP);
    w_fault_nxt = w_ready_nxt && w_fault;
    w_rdata_nxt = (w_ready_nxt && !w_fault && !w_src_write) ? w_lane_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_sel  <= '0;
      r_store_sel <= '0;
      r_is_write  <= 1'b0;
      r_invalid   <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready_nxt;
      r_rdata <= w_rdata_nxt;
      r_fault <= w_fault_nxt;
      if (w_accept) begin
        r_addr      <= mem_addr;
        r_wdata     <= mem_wdata;
        r_load_sel  <= load_sel;
        r_store_sel <= store_sel;
        r_is_write  <= mem_write_enable && !mem_read_enable;
        r_invalid   <= mem_write_enable && mem_read_enable;
        r_cnt       <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Store commits on the edge that ends RESP; reset on that edge discards it.
  always_ff @(posedge clk) begin
    if (resetn && (r_state == RESP) && w_src_write && !w_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign mem_fault = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2): vector table plus reset-abort
// and back-to-back throughput sequences.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [2:0]  lsel;
  logic [1:0]  ssel;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_fault;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_read_enable  (rd_en),
    .mem_write_enable (wr_en),
    .mem_addr         (addr),
    .mem_wdata        (wdata),
    .load_sel         (lsel),
    .store_sel        (ssel),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .mem_fault        (mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  lsel;
    logic [1:0]  ssel;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] ls, input logic [1:0] ss,
                     input logic [31:0] er, input logic ef);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.lsel = ls; v.ssel = ss;
    v.exp_rdata = er; v.exp_fault = ef;
    vecs.push_back(v);
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge
  // that follows the ready pulse.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] ls, input logic [1:0] ss,
                        output logic [31:0] got_rdata, output logic got_fault, output int lat);
    rd_en = r; wr_en = w; addr = a; wdata = d; lsel = ls; ssel = ss;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (!mem_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got_rdata = mem_rdata;
    got_fault = mem_fault;
    @(posedge clk); #1;
    check("pulse_width", {31'd0, mem_ready}, 32'd0);
  endtask

  logic [31:0] g_rdata;
  logic        g_fault;
  int          g_lat;
  int          seen;
  int          last_hit;

  initial begin
    resetn = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; wdata = '0; lsel = '0; ssel = '0;

    add(0, 1, 32'h10,   32'hDEADBEEF, 3'b010, 2'b10, 32'h0,        0);
    add(1, 0, 32'h10,   32'h0,        3'b010, 2'b00, 32'hDEADBEEF, 0);
    add(0, 1, 32'h11,   32'h00000080, 3'b000, 2'b00, 32'h0,        0);
    add(1, 0, 32'h11,   32'h0,        3'b000, 2'b00, 32'hFFFFFF80, 0);
    add(1, 0, 32'h11,   32'h0,        3'b100, 2'b00, 32'h00000080, 0);
    add(1, 0, 32'h10,   32'h0,        3'b010, 2'b00, 32'hDEAD80EF, 0);
    add(0, 1, 32'h12,   32'h00001234, 3'b000, 2'b01, 32'h0,        0);
    add(1, 0, 32'h12,   32'h0,        3'b101, 2'b00, 32'h00001234, 0);
    add(1, 0, 32'h10,   32'h0,        3'b001, 2'b00, 32'hFFFF80EF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(1, 0, 32'h13,   32'h0,        3'b010, 2'b00, 32'h0,        1);
    add(1, 0, 32'h13,   32'h0,        3'b001, 2'b00, 32'h0,        1);
`else
    add(1, 0, 32'h13,   32'h0,        3'b010, 2'b00, 32'h123480EF, 0);
    add(1, 0, 32'h13,   32'h0,        3'b001, 2'b00, 32'h00001234, 0);
`endif
    add(1, 0, 32'h1000, 32'h0,        3'b010, 2'b00, 32'h0,        1);
    add(1, 1, 32'h10,   32'h0,        3'b010, 2'b10, 32'h0,        1);
    add(1, 0, 32'h10,   32'h0,        3'b010, 2'b00, 32'h123480EF, 0);
    add(0, 1, 32'h10,   32'h0,        3'b000, 2'b11, 32'h0,        1);
    add(1, 0, 32'h10,   32'h0,        3'b010, 2'b00, 32'h123480EF, 0);
    add(1, 0, 32'h10,   32'h0,        3'b011, 2'b00, 32'h0,        1);
    add(0, 1, 32'hFFC,  32'hA5A55A5A, 3'b000, 2'b10, 32'h0,        0);
    add(1, 0, 32'hFFC,  32'h0,        3'b010, 2'b00, 32'hA5A55A5A, 0);
    add(0, 1, 32'h20,   32'h11111111, 3'b000, 2'b10, 32'h0,        0);
    add(1, 0, 32'h20,   32'h0,        3'b010, 2'b00, 32'h11111111, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_fault", {31'd0, mem_fault}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lsel, vecs[i].ssel,
             g_rdata, g_fault, g_lat);
      check($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(LAT));
      check($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_fault", i), {31'd0, g_fault}, {31'd0, vecs[i].exp_fault});
    end

    // Reset pulsed while an SW to 0x20 sits in WAIT: no response, no write.
    rd_en = 1'b0; wr_en = 1'b1; addr = 32'h20; wdata = 32'h22222222; ssel = 2'b10;
    @(posedge clk); #1;
    wr_en = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_ready) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    access(1, 0, 32'h20, 32'h0, 3'b010, 2'b00, g_rdata, g_fault, g_lat);
    check("abort_prior_data", g_rdata, 32'h11111111);
    check("abort_prior_fault", {31'd0, g_fault}, 32'd0);

    // Read enable held high; write enable toggled only while busy.
    rd_en = 1'b1; addr = 32'h10; lsel = 3'b010; ssel = 2'b10; wdata = 32'hFFFFFFFF;
    seen = 0;
    last_hit = -1;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      wr_en = ((c % 3) != 2);
      if (mem_ready) begin
        check("stream_rdata", mem_rdata, 32'h123480EF);
        check("stream_fault", {31'd0, mem_fault}, 32'd0);
        if (last_hit >= 0) check("stream_period", 32'(c - last_hit), 32'(LAT + 1));
        last_hit = c;
        seen++;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    check("stream_pulses", 32'(seen), 32'd4);
    repeat (4) @(posedge clk);
    #1;
    access(1, 0, 32'h10, 32'h0, 3'b010, 2'b00, g_rdata, g_fault, g_lat);
    check("stream_no_write", g_rdata, 32'h123480EF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
